// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
  localparam int unsigned KEY_EVT_W      = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK
  } ps2_state_e;

  // bits[7:0] data, bits[8] parity, bits[9] stop
  function automatic logic frame_good(input logic [9:0] bits);
    return (^bits[8:0]) & bits[9];
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO with sticky overflow flag.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, do_pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i & (~full | do_pop);

  // Pointer and overflow next state
  always_comb begin
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
    ovf_d = ovf_q | (push_i & full & ~do_pop);
  end

  // Pointer and overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o     = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign empty_o    = empty;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 keyboard receiver: synchronise, frame, check, fold prefixes, buffer events.
module ps2_keyboard_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic       clk_s1_q, clk_s2_q, clk_hist_q;
  logic       dat_s1_q, dat_s2_q;
  logic       fe;

  ps2_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] sr_q, sr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic       err_q, err_d;
  logic       tmo_hit;
  logic       push;
  key_event_t evt, head;
  logic [KEY_EVT_W-1:0] head_raw;
  logic       fifo_empty;

  // Input synchronisers plus ps2_clk history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_hist_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_hist_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fe      = clk_hist_q & ~clk_s2_q;
  assign tmo_hit = (state_q == ST_RECV) && !fe && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Framer state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      tmo_q   <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tmo_q   <= tmo_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      err_q   <= err_d;
    end
  end

  // Framer next state: bit collection and inactivity timer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (fe && !dat_s2_q) begin
          state_d = ST_RECV;
          cnt_d   = 4'd1;
        end
      end
      ST_RECV: begin
        if (fe) begin
          sr_d  = {dat_s2_q, sr_q[9:1]};
          cnt_d = cnt_q + 4'd1;
          tmo_d = '0;
          if (cnt_q == 4'(PS2_FRAME_BITS - 1)) state_d = ST_CHECK;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Framer outputs: error pulse, prefix folding, event push
  always_comb begin
    err_d = 1'b0;
    push  = 1'b0;
    ext_d = ext_q;
    brk_d = brk_q;
    evt   = '{ext: ext_q, brk: brk_q, code: sr_q[7:0]};
    unique case (state_q)
      ST_RECV: begin
        if (tmo_hit) begin
          err_d = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (frame_good(sr_q)) begin
          if (sr_q[7:0] == PS2_PREFIX_EXT) begin
            ext_d = 1'b1;
          end else if (sr_q[7:0] == PS2_PREFIX_BRK) begin
            brk_d = 1'b1;
          end else begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end else begin
          err_d = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_EVT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pop_i      (rd_en),
    .din_i      (evt),
    .dout_o     (head_raw),
    .empty_o    (fifo_empty),
    .overflow_o (overflow)
  );

  assign head      = key_event_t'(head_raw);
  assign key_valid = ~fifo_empty;
  assign key_code  = head.code;
  assign key_ext   = head.ext;
  assign key_break = head.brk;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Self-checking bench for ps2_keyboard_ctrl with a queue-based event model.
module tb_ps2_keyboard_ctrl;

  localparam int unsigned TMO   = 2000;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned HALF  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rd_en = 1'b0;
  logic       key_valid, key_ext, key_break, frame_err, overflow;
  logic [7:0] key_code;

  int unsigned tests_run = 0;
  int unsigned fails = 0;
  int unsigned err_seen = 0;
  int unsigned err_exp = 0;

  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic       m_ovf = 1'b0;
  logic [9:0] exp_q [$];

  ps2_keyboard_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2c),
    .ps2_data  (ps2d),
    .rd_en     (rd_en),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_seen++;

  task automatic ps2_bit(input logic b);
    ps2d = b;
    repeat (HALF) @(posedge clk);
    ps2c = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2c = 1'b1;
  endtask

  // Drives one frame and applies the prefix/FIFO rules to the model.
  task automatic send_key(input logic [7:0] code, input logic bad);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ bad, code, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    repeat (6) @(posedge clk);
    if (bad) begin
      err_exp++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (code == 8'hE0) begin
      m_ext = 1'b1;
    end else if (code == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, code});
      else m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({key_valid, key_code, key_ext, key_break, frame_err, overflow} !== 13'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {key_valid, key_code, key_ext, key_break, frame_err, overflow});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    send_key(8'h1C, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({key_valid, key_ext, key_break, key_code} !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
      fails++;
      $display("FAIL single_head: got %h expected %h",
               {key_valid, key_ext, key_break, key_code}, {1'b1, 1'b0, 1'b0, 8'h1C});
    end
    tests_run++;
    if (err_seen !== err_exp) begin
      fails++;
      $display("FAIL single_no_err: got %0d errors expected %0d", err_seen, err_exp);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    tests_run++;
    if ({key_valid, key_ext, key_break, key_code} !== 11'h0) begin
      fails++;
      $display("FAIL single_popped: got %h expected 0", {key_valid, key_ext, key_break, key_code});
    end
    exp_q.delete();
  endtask

  task automatic test_prefix;
    send_key(8'hE0, 1'b0);
    send_key(8'hF0, 1'b0);
    send_key(8'h75, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({key_valid, key_ext, key_break, key_code} !== {1'b1, 1'b1, 1'b1, 8'h75}) begin
      fails++;
      $display("FAIL prefix_event: got %h expected %h",
               {key_valid, key_ext, key_break, key_code}, {1'b1, 1'b1, 1'b1, 8'h75});
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    tests_run++;
    if (key_valid !== 1'b0) begin
      fails++;
      $display("FAIL prefix_single_event: got valid=%b expected 0", key_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_parity;
    int unsigned e0;
    send_key(8'hE0, 1'b0);
    send_key(8'hF0, 1'b0);
    e0 = err_seen;
    send_key(8'h1C, 1'b1);
    @(negedge clk);
    tests_run++;
    if (err_seen !== e0 + 1) begin
      fails++;
      $display("FAIL parity_err_pulse: got %0d pulses expected 1", err_seen - e0);
    end
    tests_run++;
    if (key_valid !== 1'b0) begin
      fails++;
      $display("FAIL parity_no_event: got valid=%b expected 0", key_valid);
    end
    send_key(8'h1B, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({key_valid, key_ext, key_break, key_code} !== {1'b1, 1'b0, 1'b0, 8'h1B}) begin
      fails++;
      $display("FAIL parity_flags_cleared: got %h expected %h",
               {key_valid, key_ext, key_break, key_code}, {1'b1, 1'b0, 1'b0, 8'h1B});
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 9; i++) begin
      send_key(8'(i), 1'b0);
      if (i == 8) begin
        tests_run++;
        if (overflow !== 1'b0) begin
          fails++;
          $display("FAIL ovf_at_full: got %b expected 0", overflow);
        end
      end
    end
    @(negedge clk);
    tests_run++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_after_ninth: got %b expected 1", overflow);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tests_run++;
      if ({key_valid, key_code} !== {1'b1, 8'(k)}) begin
        fails++;
        $display("FAIL ovf_drain_%0d: got %h expected %h", k, {key_valid, key_code}, {1'b1, 8'(k)});
      end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    tests_run++;
    if ({key_valid, overflow} !== 2'b01) begin
      fails++;
      $display("FAIL ovf_after_drain: got valid,ovf=%b expected 01", {key_valid, overflow});
    end
    exp_q.delete();
  endtask

  task automatic test_timeout;
    int unsigned e0;
    send_key(8'hE0, 1'b0);
    e0 = err_seen;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit($urandom_range(0, 1) != 0);
    repeat (TMO + 20) @(posedge clk);
    err_exp++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    @(negedge clk);
    tests_run++;
    if (err_seen !== e0 + 1) begin
      fails++;
      $display("FAIL timeout_err_pulse: got %0d pulses expected 1", err_seen - e0);
    end
    send_key(8'h2A, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({key_valid, key_ext, key_break, key_code} !== {1'b1, 1'b0, 1'b0, 8'h2A}) begin
      fails++;
      $display("FAIL timeout_recover: got %h expected %h",
               {key_valid, key_ext, key_break, key_code}, {1'b1, 1'b0, 1'b0, 8'h2A});
    end
    tests_run++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset_midframe;
    send_key(8'h33, 1'b0);
    send_key(8'hF0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit($urandom_range(0, 1) != 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({key_valid, key_code, key_ext, key_break, frame_err, overflow} !== 13'h0) begin
      fails++;
      $display("FAIL midframe_reset_outputs: got %h expected 0",
               {key_valid, key_code, key_ext, key_break, frame_err, overflow});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    send_key(8'h29, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({key_valid, key_ext, key_break, key_code} !== {1'b1, 1'b0, 1'b0, 8'h29}) begin
      fails++;
      $display("FAIL midframe_next_frame: got %h expected %h",
               {key_valid, key_ext, key_break, key_code}, {1'b1, 1'b0, 1'b0, 8'h29});
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_random;
    logic [7:0]  code;
    logic        bad;
    int unsigned n;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0:       code = 8'hE0;
        1:       code = 8'hF0;
        default: begin
          code = 8'($urandom);
          if (code == 8'hE0 || code == 8'hF0) code = 8'h5A;
        end
      endcase
      bad = ($urandom_range(0, 9) == 0);
      send_key(code, bad);
      if ($urandom_range(0, 4) == 0 || it == 59) begin
        n = exp_q.size();
        for (int k = 0; k < int'(n); k++) begin
          @(negedge clk);
          tests_run++;
          if ({key_valid, key_ext, key_break, key_code} !== {1'b1, exp_q[0]}) begin
            fails++;
            $display("FAIL random_event: got %h expected %h",
                     {key_valid, key_ext, key_break, key_code}, {1'b1, exp_q[0]});
          end
          void'(exp_q.pop_front());
          rd_en = 1'b1;
          @(negedge clk);
          rd_en = 1'b0;
        end
        @(negedge clk);
        tests_run++;
        if (key_valid !== 1'b0) begin
          fails++;
          $display("FAIL random_empty: got valid=%b expected 0", key_valid);
        end
      end
    end
    tests_run++;
    if (overflow !== m_ovf) begin
      fails++;
      $display("FAIL random_overflow: got %b expected %b", overflow, m_ovf);
    end
    tests_run++;
    if (err_seen !== err_exp) begin
      fails++;
      $display("FAIL frame_err_total: got %0d expected %0d", err_seen, err_exp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_ctrl.md
Name: ps2_keyboard_ctrl

Overview:
Receive-side controller for the PS/2 keyboard line. It synchronises ps2_clk and ps2_data, frames 11-bit PS/2 packets and checks start, odd parity and stop. It folds E0/F0 prefix bytes into key events and buffers the events in a small FIFO for the display/logic layer. It is the consumer of the keyboard bus model's 11-bit frames in system simulation.

Parameters:
TIMEOUT_CYCLES, 2000, clk cycles without a ps2_clk falling edge before a partial frame is aborted
FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from keyboard (asynchronous)
ps2_data  input  1  raw PS/2 data from keyboard (asynchronous)
rd_en  input  1  pop head event; ignored when key_valid=0
key_valid  output  1  FIFO non-empty
key_code  output  8  head event scan code (first-word-fall-through)
key_ext  output  1  head event was E0-prefixed
key_break  output  1  head event was F0-prefixed (key release)
frame_err  output  1  one-cycle pulse on parity, start/stop or timeout error
overflow  output  1  sticky; an event was dropped because the FIFO was full

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO empty, FSM IDLE, bit counter 0, ext/brk flags 0, synchroniser flops 1. Reset mid-frame discards the partial frame.
- Synchronisation: 2-flop synchronisers on ps2_clk and ps2_data plus one history flop on ps2_clk. Falling edge fe = hist & ~sync. Data is sampled from the synchronised ps2_data on fe.
- Input requirement: ps2_clk high and low phases each >= 3 clk cycles. Data is stable across the falling edge.
- FSM IDLE: on fe with data=0 (start bit), go to RECV with count=1. On fe with data=1, ignore and stay in IDLE.
- FSM RECV: on each fe, shift the bit in and increment count. Bits 1-8 are data, LSB first. Bit 9 is parity. Bit 10 is stop.
- Frame check at count 10 on fe: go to CHECK for one cycle. Frame is good iff (^data ^ parity)==1 and stop==1. Bad frame: frame_err pulses, ext/brk are cleared, FSM returns to IDLE.
- Timeout: a cycle counter resets on every fe while in RECV. Reaching TIMEOUT_CYCLES-1 without an fe pulses frame_err, clears ext/brk and returns to IDLE.
- Prefix folding on a good byte:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte pushes {ext, brk, code} and then clears both flags.
  - Repeated prefixes are idempotent.
- Latency: the push occurs in the CHECK cycle. key_valid rises on the next clk edge.
- FIFO: first-word-fall-through. Outputs show the head entry while key_valid=1 and are 0 when empty.
  - Pop on rd_en & key_valid.
  - Push while full with no pop: event dropped, overflow set (held until rst), contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty: the push occurs and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer MSB.

Decomposition:
- Shared package ps2_pkg: PS2_FRAME_BITS=11, PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, KEY_EVT_W=10, and a typedef for key_event {ext, brk, code[7:0]}.
- One sub-module, ps2_event_fifo (parameterised depth/width, FWFT, full/empty/overflow). The framer FSM and prefix folding stay in the top.

Test Plan:
- Send frame 0x1C, odd parity 0, with rd_en=0 -> key_valid=1, key_code=0x1C, key_ext=0, key_break=0, frame_err never pulses. Then rd_en for one cycle -> key_valid=0.
- Send E0, F0, 75 back-to-back -> exactly one event {ext=1, brk=1, code=0x75}; the prefix bytes produce no events.
- Send 0x1C with its parity bit inverted -> one frame_err pulse, no event. A following plain 0x1B yields {0,0,0x1B}, so the flags were cleared.
- Send 9 make codes 0x01..0x09 with no reads -> 8 entries, overflow=1 after the 9th. Popping yields 0x01..0x08 in order, then key_valid=0. overflow stays 1 until rst.
- Send start plus 4 data bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses once, FSM returns to IDLE, and the next full frame 0x2A decodes correctly.
- Assert rst for 2 cycles after bit 5 of a frame -> all outputs 0. Subsequent complete frame 0x29 decodes as {0,0,0x29}.
